// File: rtl/ldm_xfer_pkg.sv
// Shared definitions for the LDM/STM memory-side transfer unit.
package ldm_xfer_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam logic [3:0]  PC_REG_CODE     = 4'd15;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic        l;
        logic [31:0] addr;
        logic [3:0]  reg_code;
        logic [31:0] wdata;
        logic        last;
    } xfer_entry_t;

    function automatic logic [31:0] align_addr(input logic [31:0] a);
        return a & ADDR_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/ldm_xfer_fifo.sv
// Transfer FIFO: DEPTH entries, registered occupancy, combinational head read.
// Callers must never push when full or pop when empty.
module ldm_xfer_fifo
    import ldm_xfer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  xfer_entry_t wr_entry,
    output xfer_entry_t rd_entry,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    xfer_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_entry = mem[rd_ptr];
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);

endmodule

// File: rtl/ldm_xfer_unit.sv
// Memory-side executor for LDM/STM block transfers: buffers per-register
// transfers, issues them on the dmem req/ack bus, and writes back load data.
//
// state | meaning
// IDLE  | no request outstanding; launch from FIFO head when en
// REQ   | request on the bus, held stable until ack
module ldm_xfer_unit
    import ldm_xfer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        i_xfer_vld,
    input  logic        i_xfer_l,
    input  logic [31:0] i_xfer_base,
    input  logic [31:0] i_xfer_offset,
    input  logic [3:0]  i_xfer_reg_code,
    input  logic [31:0] i_xfer_wdata,
    input  logic        i_xfer_last,
    output logic        o_xfer_ready,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_rf_we,
    output logic [3:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata,
    output logic        o_pc_load,
    output logic [31:0] o_pc_value,
    output logic        o_xfer_busy,
    output logic        o_xfer_done
);

    logic [0:0]  state;
    xfer_entry_t req_q;
    xfer_entry_t head;
    xfer_entry_t new_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        ack_fire;

    // Pack the incoming transfer; address is computed and aligned at push time.
    always_comb begin
        new_entry          = '0;
        new_entry.l        = i_xfer_l;
        new_entry.addr     = align_addr(i_xfer_base + i_xfer_offset);
        new_entry.reg_code = i_xfer_reg_code;
        new_entry.wdata    = i_xfer_wdata;
        new_entry.last     = i_xfer_last;
    end

    assign push     = i_xfer_vld & ~fifo_full & en;
    assign ack_fire = (state == ST_REQ) & i_dmem_ack;
    assign pop      = ~fifo_empty & en & ((state == ST_IDLE) | ack_fire);

    ldm_xfer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .wr_entry (new_entry),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Request FSM: a pop always lands in the request register and enters REQ,
    // which gives back-to-back issue when the next entry is ready at ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            req_q <= '0;
        end else if (pop) begin
            state <= ST_REQ;
            req_q <= head;
        end else if (ack_fire) begin
            state <= ST_IDLE;
        end
    end

    // Completion slot one cycle after ack: register-file write, PC load, done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rf_we     <= 1'b0;
            o_rf_waddr  <= '0;
            o_rf_wdata  <= '0;
            o_pc_load   <= 1'b0;
            o_pc_value  <= '0;
            o_xfer_done <= 1'b0;
        end else begin
            o_rf_we     <= 1'b0;
            o_pc_load   <= 1'b0;
            o_xfer_done <= 1'b0;
            if (ack_fire) begin
                o_xfer_done <= req_q.last;
                if (req_q.l) begin
                    if (req_q.reg_code == PC_REG_CODE) begin
                        o_pc_load  <= 1'b1;
                        o_pc_value <= i_dmem_rdata & ADDR_ALIGN_MASK;
                    end else begin
                        o_rf_we    <= 1'b1;
                        o_rf_waddr <= req_q.reg_code;
                        o_rf_wdata <= i_dmem_rdata;
                    end
                end
            end
        end
    end

    assign o_xfer_ready = ~fifo_full;
    assign o_dmem_req   = (state == ST_REQ);
    assign o_dmem_we    = (state == ST_REQ) & ~req_q.l;
    assign o_dmem_addr  = req_q.addr;
    assign o_dmem_wdata = req_q.wdata;
    assign o_xfer_busy  = ~fifo_empty | (state == ST_REQ);

endmodule
